// File: rtl/ob_arb.sv
// ============================================================================
// Module   : ob_arb
// Purpose  : Output-port arbiter and packet forwarder. Grants one input
//            buffer at a time, acks its flits head through tail, forwards
//            them onto a registered output and honours downstream `full`.
// Options  : OB_ARB_RR_EN - round-robin arbitration (default: fixed priority,
//            lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PKTW
`define PKTW 9
`endif

module ob_arb #(
    parameter int NIN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NIN-1:0]             req,
    input  logic [NIN*(`PKTW+1)-1:0]   pkti,
    output logic [NIN-1:0]             ack,
    input  logic                       full,
    output logic [`PKTW:0]             pkto,
    output logic                       busy,
    output logic [7:0]                 pkt_cnt
);

    localparam int         FW          = `PKTW + 1;
    localparam int         GW          = (NIN > 1) ? $clog2(NIN) : 1;
    localparam logic [1:0] C_TYPE_TAIL = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_gnt;
    logic [GW-1:0]   w_gnt_nxt;
    logic [GW-1:0]   w_winner;
    logic [FW-1:0]   w_flit;
    logic            w_take;
    logic            w_tail;
    logic            w_tail_fwd;

    // Flit currently presented by the granted buffer and its classification
    assign w_flit     = pkti[r_gnt*FW +: FW];
    assign w_take     = (r_state == XFER) && !full;
    assign w_tail     = (w_flit[FW-1 -: 2] == C_TYPE_TAIL);
    assign w_tail_fwd = w_take && w_tail;

`ifdef OB_ARB_RR_EN
    logic [GW-1:0] r_rr;

    // Round-robin pick: first set request searching upward from r_rr, wrapping.
    // Iterating from the far end down lets the nearest hit overwrite the rest.
    always_comb begin
        w_winner = r_rr;
        for (int i = NIN - 1; i >= 0; i--) begin
            if (req[(int'(r_rr) + i) % NIN]) begin
                w_winner = GW'((int'(r_rr) + i) % NIN);
            end
        end
    end

    // Pointer advances past the winner only once its tail has gone out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_tail_fwd) begin
            r_rr <= (r_gnt == GW'(NIN - 1)) ? '0 : r_gnt + GW'(1);
        end
    end
`else
    // Fixed priority pick: lowest-index set request wins
    always_comb begin
        w_winner = '0;
        for (int i = NIN - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_winner = GW'(i);
            end
        end
    end
`endif

    // Ack only the granted buffer, and only when downstream can take the flit
    always_comb begin
        ack = '0;
        if (w_take) begin
            ack[r_gnt] = 1'b1;
        end
    end

    // Next state: grant on any request from IDLE, release after the tail
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = XFER;
                    w_gnt_nxt   = w_winner;
                end
            end
            XFER: begin
                if (w_tail_fwd) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and grant registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // Output flit register: acked flit passes through, otherwise an idle flit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkto <= '0;
        end else begin
            pkto <= w_take ? w_flit : '0;
        end
    end

    // Forwarded-packet counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (w_tail_fwd) begin
            pkt_cnt <= pkt_cnt + 8'd1;
        end
    end

    assign busy = (r_state == XFER);

endmodule

`default_nettype wire

// File: tb/tb_ob_arb.sv
// ============================================================================
// Module   : tb_ob_arb
// Purpose  : Self-checking bench for ob_arb: vector table for single-packet,
//            back-pressure and idle-flit cases, plus hand sequences for
//            mid-packet reset, arbitration order and counter wrap.
// Options  : honours OB_ARB_RR_EN for the expected grant order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PKTW
`define PKTW 9
`endif

module tb_ob_arb;

    localparam int NIN = 4;
    localparam int FW  = `PKTW + 1;

    localparam logic [FW-1:0] C_H  = 10'h203;
    localparam logic [FW-1:0] C_B0 = 10'h100;
    localparam logic [FW-1:0] C_B1 = 10'h101;
    localparam logic [FW-1:0] C_T  = 10'h300;
    localparam logic [FW-1:0] C_I  = 10'h05A;
    localparam logic [FW-1:0] C_Z  = 10'h000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NIN-1:0]       req = '0;
    logic [NIN*FW-1:0]    pkti;
    logic [NIN-1:0]       ack;
    logic                 full = 1'b0;
    logic [FW-1:0]        pkto;
    logic                 busy;
    logic [7:0]           pkt_cnt;

    int                   n_vec = 0;
    int                   n_err = 0;

    logic                 mode = 1'b0;
    int                   t_src = 0;
    logic [FW-1:0]        t_flit = '0;
    logic [NIN-1:0]       ptr;

    typedef struct {
        logic           rst;
        logic [NIN-1:0] req;
        int             src;
        logic [FW-1:0]  flit;
        logic           full;
        logic [NIN-1:0] e_ack;
        logic [FW-1:0]  e_pkto;
        logic           e_busy;
        logic [7:0]     e_cnt;
    } vec_t;

    vec_t vq[$];

    ob_arb #(.NIN(NIN)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .pkti    (pkti),
        .ack     (ack),
        .full    (full),
        .pkto    (pkto),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] head_f(input int j);
        return FW'(32'h200 + j);
    endfunction

    function automatic logic [FW-1:0] tail_f(input int j);
        return FW'(32'h310 + j);
    endfunction

    function automatic logic [FW-1:0] noise_f(input int j);
        return FW'(32'h3E0 + j);
    endfunction

    function automatic int exp_g(input int k);
`ifdef OB_ARB_RR_EN
        return k % NIN;
`else
        return 0 * k;
`endif
    endfunction

    // Upstream buffers in model mode: 2-flit packets, advance on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            for (int j = 0; j < NIN; j++) begin
                if (ack[j]) ptr[j] <= ~ptr[j];
            end
        end
    end

    // Flit bus: model buffers or table-driven flit on one source, noise elsewhere
    always_comb begin
        pkti = '0;
        for (int j = 0; j < NIN; j++) begin
            if (mode)            pkti[j*FW +: FW] = ptr[j] ? tail_f(j) : head_f(j);
            else if (j == t_src) pkti[j*FW +: FW] = t_flit;
            else                 pkti[j*FW +: FW] = noise_f(j);
        end
    end

    task automatic check(input string name, input logic [NIN-1:0] e_ack,
                         input logic [FW-1:0] e_pkto, input logic e_busy,
                         input logic [7:0] e_cnt);
        n_vec++;
        if (ack !== e_ack) begin
            n_err++;
            $display("FAIL %s ack got %b want %b", name, ack, e_ack);
        end
        if (pkto !== e_pkto) begin
            n_err++;
            $display("FAIL %s pkto got %h want %h", name, pkto, e_pkto);
        end
        if (busy !== e_busy) begin
            n_err++;
            $display("FAIL %s busy got %b want %b", name, busy, e_busy);
        end
        if (pkt_cnt !== e_cnt) begin
            n_err++;
            $display("FAIL %s pkt_cnt got %0d want %0d", name, pkt_cnt, e_cnt);
        end
    endtask

    initial begin
        int k, ph, g;
        logic [FW-1:0] ep;

        //          rst   req     src flit full  e_ack   e_pkto e_busy e_cnt
        vq.push_back('{1'b1, 4'b1111, 2, C_H,  1'b0, 4'b0000, C_Z,  1'b0, 8'd0});
        vq.push_back('{1'b0, 4'b0100, 2, C_H,  1'b0, 4'b0000, C_Z,  1'b0, 8'd0});
        vq.push_back('{1'b0, 4'b0100, 2, C_H,  1'b0, 4'b0100, C_Z,  1'b1, 8'd0});
        vq.push_back('{1'b0, 4'b0100, 2, C_B0, 1'b0, 4'b0100, C_H,  1'b1, 8'd0});
        vq.push_back('{1'b0, 4'b0100, 2, C_B1, 1'b0, 4'b0100, C_B0, 1'b1, 8'd0});
        vq.push_back('{1'b0, 4'b0100, 2, C_T,  1'b0, 4'b0100, C_B1, 1'b1, 8'd0});
        vq.push_back('{1'b0, 4'b0000, 2, C_Z,  1'b0, 4'b0000, C_T,  1'b0, 8'd1});
        vq.push_back('{1'b0, 4'b0000, 2, C_Z,  1'b0, 4'b0000, C_Z,  1'b0, 8'd1});
        // back-pressure after head, then full coinciding with the tail
        vq.push_back('{1'b0, 4'b0100, 2, C_H,  1'b0, 4'b0000, C_Z,  1'b0, 8'd1});
        vq.push_back('{1'b0, 4'b0100, 2, C_H,  1'b0, 4'b0100, C_Z,  1'b1, 8'd1});
        vq.push_back('{1'b0, 4'b0100, 2, C_B0, 1'b1, 4'b0000, C_H,  1'b1, 8'd1});
        vq.push_back('{1'b0, 4'b0100, 2, C_B0, 1'b1, 4'b0000, C_Z,  1'b1, 8'd1});
        vq.push_back('{1'b0, 4'b0100, 2, C_B0, 1'b0, 4'b0100, C_Z,  1'b1, 8'd1});
        vq.push_back('{1'b0, 4'b0100, 2, C_B1, 1'b0, 4'b0100, C_B0, 1'b1, 8'd1});
        vq.push_back('{1'b0, 4'b0100, 2, C_T,  1'b1, 4'b0000, C_B1, 1'b1, 8'd1});
        vq.push_back('{1'b0, 4'b0100, 2, C_T,  1'b0, 4'b0100, C_Z,  1'b1, 8'd1});
        vq.push_back('{1'b0, 4'b0000, 2, C_Z,  1'b0, 4'b0000, C_T,  1'b0, 8'd2});
        vq.push_back('{1'b0, 4'b0000, 2, C_Z,  1'b0, 4'b0000, C_Z,  1'b0, 8'd2});
        // idle flit mid-packet forwarded; req change mid-packet ignored
        vq.push_back('{1'b0, 4'b0010, 1, C_H,  1'b0, 4'b0000, C_Z,  1'b0, 8'd2});
        vq.push_back('{1'b0, 4'b0010, 1, C_H,  1'b0, 4'b0010, C_Z,  1'b1, 8'd2});
        vq.push_back('{1'b0, 4'b0001, 1, C_I,  1'b0, 4'b0010, C_H,  1'b1, 8'd2});
        vq.push_back('{1'b0, 4'b0001, 1, C_T,  1'b0, 4'b0010, C_I,  1'b1, 8'd2});
        vq.push_back('{1'b0, 4'b0000, 1, C_Z,  1'b0, 4'b0000, C_T,  1'b0, 8'd3});

        foreach (vq[i]) begin
            @(negedge clk);
            rst    = vq[i].rst;
            req    = vq[i].req;
            t_src  = vq[i].src;
            t_flit = vq[i].flit;
            full   = vq[i].full;
            #1;
            check($sformatf("vec%0d", i), vq[i].e_ack, vq[i].e_pkto,
                  vq[i].e_busy, vq[i].e_cnt);
        end

        // Mid-packet reset: ack must drop asynchronously, count stays 0
        @(negedge clk);
        rst = 1'b1; req = '0; full = 1'b0;
        #1 check("mr_rst", 4'b0000, C_Z, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0; req = 4'b1000; t_src = 3; t_flit = C_H;
        #1 check("mr_idle", 4'b0000, C_Z, 1'b0, 8'd0);
        @(negedge clk);
        #1 check("mr_head", 4'b1000, C_Z, 1'b1, 8'd0);
        @(negedge clk);
        t_flit = C_B0;
        #1 check("mr_body", 4'b1000, C_H, 1'b1, 8'd0);
        #2 rst = 1'b1;
        #1 check("mr_async", 4'b0000, C_Z, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0; req = '0;
        #1 check("mr_after", 4'b0000, C_Z, 1'b0, 8'd0);
        @(negedge clk);
        #1 check("mr_after2", 4'b0000, C_Z, 1'b0, 8'd0);

        // Arbitration with all requests held: 2-flit packets, period 3
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mode = 1'b1; req = 4'b1111;
        for (int cyc = 0; cyc <= 3 * 256; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            k  = cyc / 3;
            ph = cyc % 3;
            g  = exp_g(k);
            if (cyc <= 15 || cyc >= 3 * 255) begin
                if (ph == 0) begin
                    ep = (k == 0) ? C_Z : tail_f(exp_g(k - 1));
                    check($sformatf("arb%0d", cyc), 4'b0000, ep, 1'b0, 8'(k));
                end else if (ph == 1) begin
                    check($sformatf("arb%0d", cyc), NIN'(1) << g, C_Z, 1'b1, 8'(k));
                end else begin
                    check($sformatf("arb%0d", cyc), NIN'(1) << g, head_f(g), 1'b1, 8'(k));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
